// File: rtl/mult_sched_pkg.sv
// Shared types and constants for the two-requester shift-add multiply scheduler.
package mult_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEFAULT_OP_W = 4;
  localparam int NUM_REQ      = 2;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: the requester named by ptr has priority,
// the other one wins only when the preferred one is idle.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  // Pick the pointed-to requester first, fall back to the other, else no grant.
  always_comb begin
    gnt = 2'b00;
    if (ptr == 1'b0) begin
      if (req[0])      gnt = 2'b01;
      else if (req[1]) gnt = 2'b10;
    end else begin
      if (req[1])      gnt = 2'b10;
      else if (req[0]) gnt = 2'b01;
    end
  end

endmodule

// File: rtl/mult_sched.sv
// Shares one shift-add multiplier between two requesters. A granted request
// runs for exactly OP_W iterations, then the product is held in DONE until
// the consumer takes it.
module mult_sched
  import mult_sched_pkg::*;
#(
  parameter int OP_W = DEFAULT_OP_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [OP_W-1:0]      req_m0,
  input  logic [OP_W-1:0]      req_q0,
  input  logic [OP_W-1:0]      req_m1,
  input  logic [OP_W-1:0]      req_q1,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*OP_W-1:0]    res_p,
  output logic                 res_id,
  output logic                 busy
);

  localparam int P_W   = 2 * OP_W;
  localparam int CNT_W = (OP_W > 1) ? $clog2(OP_W) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(OP_W - 1);

  state_e           state_q;
  logic             ptr_q;
  logic [CNT_W-1:0] iterCnt_q;
  logic [P_W-1:0]   acc_q;
  logic [P_W-1:0]   mShift_q;
  logic [OP_W-1:0]  qShift_q;
  logic             opId_q;
  logic [P_W-1:0]   resP_q;
  logic             resId_q;
  logic             resValid_q;

  logic [1:0]       gnt;
  logic [OP_W-1:0]  selM;
  logic [OP_W-1:0]  selQ;
  logic [P_W-1:0]   acc_d;

  rr_arb2 u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (gnt)
  );

  // Route the winning requester's operands toward the capture registers.
  always_comb begin
    selM = gnt[1] ? req_m1 : req_m0;
    selQ = gnt[1] ? req_q1 : req_q0;
  end

  // One iteration: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    acc_d = acc_q + (qShift_q[0] ? mShift_q : '0);
  end

  // Scheduler FSM: accept in IDLE, iterate in RUN, hold the result in DONE until handoff.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ptr_q      <= 1'b0;
      iterCnt_q  <= '0;
      acc_q      <= '0;
      mShift_q   <= '0;
      qShift_q   <= '0;
      opId_q     <= 1'b0;
      resP_q     <= '0;
      resId_q    <= 1'b0;
      resValid_q <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt != 2'b00) begin
            ptr_q     <= gnt[0];
            mShift_q  <= P_W'(selM);
            qShift_q  <= selQ;
            opId_q    <= gnt[1];
            acc_q     <= '0;
            iterCnt_q <= '0;
            state_q   <= RUN;
          end
        end
        RUN: begin
          acc_q     <= acc_d;
          mShift_q  <= mShift_q << 1;
          qShift_q  <= qShift_q >> 1;
          iterCnt_q <= iterCnt_q + CNT_W'(1);
          if (iterCnt_q == LAST_ITER) begin
            resP_q     <= acc_d;
            resId_q    <= opId_q;
            resValid_q <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            resValid_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = (!rst && state_q == IDLE) ? gnt : 2'b00;
  assign res_valid = resValid_q;
  assign res_p     = resP_q;
  assign res_id    = resId_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mult_sched.sv
// Bench for mult_sched: directed scenarios with hand-computed results plus a
// randomized run compared every cycle against an arithmetic reference model.
module tb_mult_sched;

  localparam int OP_W = 4;
  localparam int P_W  = 2 * OP_W;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req_valid;
  logic [OP_W-1:0] req_m0, req_q0, req_m1, req_q1;
  logic [1:0]      req_ready;
  logic            res_valid;
  logic            res_ready;
  logic [P_W-1:0]  res_p;
  logic            res_id;
  logic            busy;

  int assertCount = 0;
  int failCount   = 0;

  // Reference model state: phase 0 idle, 1 computing, 2 holding a result.
  int             mPhase   = 0;
  int             mRemain  = 0;
  int             mPtr     = 0;
  logic [P_W-1:0] mPending = '0;
  logic           mPendId  = 1'b0;
  logic [P_W-1:0] mLastP   = '0;
  logic           mLastId  = 1'b0;
  int             modWin;
  int             cmpWin;
  logic [1:0]     expReady;

  always #5 clk = ~clk;

  mult_sched #(.OP_W(OP_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_m0    (req_m0),
    .req_q0    (req_q0),
    .req_m1    (req_m1),
    .req_q1    (req_q1),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_p     (res_p),
    .res_id    (res_id),
    .busy      (busy)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    assertCount++;
    if (act !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] v, input logic [OP_W-1:0] m0, input logic [OP_W-1:0] q0,
                               input logic [OP_W-1:0] m1, input logic [OP_W-1:0] q1, input logic rr);
    req_valid = v;
    req_m0    = m0;
    req_q0    = q0;
    req_m1    = m1;
    req_q1    = q1;
    res_ready = rr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin winner by the rules: pointer wins a tie, a lone requester always wins.
  function automatic int winner(input logic [1:0] v, input int ptr);
    if (v == 2'b11) return ptr;
    if (v[0]) return 0;
    if (v[1]) return 1;
    return -1;
  endfunction

  // Advance the reference model on each clock edge using the inputs seen at that edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mPhase  = 0;
      mRemain = 0;
      mPtr    = 0;
      mLastP  = '0;
      mLastId = 1'b0;
    end else begin
      case (mPhase)
        0: begin
          modWin = winner(req_valid, mPtr);
          if (modWin >= 0) begin
            mPendId  = (modWin == 1);
            mPending = (modWin == 1) ? (P_W'(req_m1) * P_W'(req_q1)) : (P_W'(req_m0) * P_W'(req_q0));
            mPtr     = 1 - modWin;
            mRemain  = OP_W;
            mPhase   = 1;
          end
        end
        1: begin
          mRemain--;
          if (mRemain == 0) begin
            mLastP  = mPending;
            mLastId = mPendId;
            mPhase  = 2;
          end
        end
        default: begin
          if (res_ready) mPhase = 0;
        end
      endcase
    end
  end

  // Compare every DUT output against the model midway between clock edges.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst req_ready", {30'b0, req_ready}, 32'd0);
      checkOutput("rst res_valid", {31'b0, res_valid}, 32'd0);
      checkOutput("rst res_p", {24'b0, res_p}, 32'd0);
      checkOutput("rst res_id", {31'b0, res_id}, 32'd0);
      checkOutput("rst busy", {31'b0, busy}, 32'd0);
    end else begin
      cmpWin   = (mPhase == 0) ? winner(req_valid, mPtr) : -1;
      expReady = (cmpWin == 0) ? 2'b01 : ((cmpWin == 1) ? 2'b10 : 2'b00);
      checkOutput("req_ready", {30'b0, req_ready}, {30'b0, expReady});
      checkOutput("busy", {31'b0, busy}, {31'b0, (mPhase != 0)});
      checkOutput("res_valid", {31'b0, res_valid}, {31'b0, (mPhase == 2)});
      checkOutput("res_p", {24'b0, res_p}, {24'b0, mLastP});
      checkOutput("res_id", {31'b0, res_id}, {31'b0, mLastId});
    end
  end

  task automatic doReset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a handshake, report which requester got it, and step over the accepting edge.
  task automatic waitAccept(output int who);
    int guard = 0;
    who = -1;
    while (((req_valid & req_ready) == 2'b00) && guard < 30) begin
      tick();
      guard++;
    end
    checkOutput("accept seen", {31'b0, ((req_valid & req_ready) != 2'b00)}, 32'd1);
    if ((req_valid & req_ready) != 2'b00) who = req_ready[1] ? 1 : 0;
    tick();
  endtask

  // Wait (bounded) for res_valid; lat counts edges since the caller's last edge.
  task automatic waitResult(output int lat, output logic [P_W-1:0] p, output logic id);
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!res_valid && lat < 40);
    checkOutput("result seen", {31'b0, res_valid}, 32'd1);
    p  = res_p;
    id = res_id;
  endtask

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stimulus
    int             who;
    int             lat;
    int             extraValid;
    logic [P_W-1:0] p;
    logic           id;

    rst = 1'b1;
    applyStimulus(2'b00, '0, '0, '0, '0, 1'b1);
    tick();
    tick();
    rst = 1'b0;

    // Single operation 15*15 with the latency pinned.
    applyStimulus(2'b01, 4'd15, 4'd15, 4'd0, 4'd0, 1'b1);
    waitAccept(who);
    checkOutput("single grant", who, 32'd0);
    applyStimulus(2'b00, 4'd1, 4'd1, 4'd1, 4'd1, 1'b1);
    waitResult(lat, p, id);
    checkOutput("single latency", lat, 32'd4);
    checkOutput("single product", {24'b0, p}, 32'd225);
    checkOutput("single id", {31'b0, id}, 32'd0);
    tick();
    checkOutput("single idle after handoff", {31'b0, busy}, 32'd0);

    // Contention right after reset: requester 0 first, then 1; operand churn must not leak in.
    doReset();
    applyStimulus(2'b11, 4'd7, 4'd2, 4'd3, 4'd5, 1'b1);
    waitAccept(who);
    checkOutput("contend first grant", who, 32'd0);
    applyStimulus(2'b11, 4'd9, 4'd9, 4'd3, 4'd5, 1'b1);
    waitResult(lat, p, id);
    checkOutput("contend first product", {24'b0, p}, 32'd14);
    checkOutput("contend first id", {31'b0, id}, 32'd0);
    tick();
    waitAccept(who);
    checkOutput("contend second grant", who, 32'd1);
    applyStimulus(2'b00, 4'd15, 4'd15, 4'd15, 4'd15, 1'b1);
    waitResult(lat, p, id);
    checkOutput("contend second product", {24'b0, p}, 32'd15);
    checkOutput("contend second id", {31'b0, id}, 32'd1);
    tick();

    // Backpressure on a requester-1 result of 6*7.
    applyStimulus(2'b10, 4'd0, 4'd0, 4'd6, 4'd7, 1'b0);
    waitAccept(who);
    checkOutput("bp grant", who, 32'd1);
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    waitResult(lat, p, id);
    checkOutput("bp latency", lat, 32'd4);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(2'(($urandom_range(1, 3))), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0);
      checkOutput("bp req_ready", {30'b0, req_ready}, 32'd0);
      tick();
      checkOutput("bp res_valid", {31'b0, res_valid}, 32'd1);
      checkOutput("bp res_p", {24'b0, res_p}, 32'd42);
      checkOutput("bp res_id", {31'b0, res_id}, 32'd1);
    end
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    tick();
    checkOutput("bp handoff res_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("bp handoff busy", {31'b0, busy}, 32'd0);

    // Reset during the third iteration throws the operation away.
    applyStimulus(2'b01, 4'd5, 4'd5, 4'd0, 4'd0, 1'b1);
    waitAccept(who);
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("abort res_valid", {31'b0, res_valid}, 32'd0);
    checkOutput("abort res_p", {24'b0, res_p}, 32'd0);
    checkOutput("abort res_id", {31'b0, res_id}, 32'd0);
    checkOutput("abort busy", {31'b0, busy}, 32'd0);
    tick();
    rst = 1'b0;
    extraValid = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (res_valid) extraValid++;
    end
    checkOutput("abort no result", extraValid, 32'd0);
    applyStimulus(2'b11, 4'd2, 4'd3, 4'd1, 4'd1, 1'b1);
    waitAccept(who);
    checkOutput("post-abort grant", who, 32'd0);
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    waitResult(lat, p, id);
    checkOutput("post-abort product", {24'b0, p}, 32'd6);
    checkOutput("post-abort id", {31'b0, id}, 32'd0);
    tick();

    // Zero multiplicand still runs the full iteration count.
    applyStimulus(2'b01, 4'd0, 4'd9, 4'd0, 4'd0, 1'b1);
    waitAccept(who);
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    checkOutput("zero busy in run", {31'b0, busy}, 32'd1);
    waitResult(lat, p, id);
    checkOutput("zero latency", lat, 32'd4);
    checkOutput("zero product", {24'b0, p}, 32'd0);
    checkOutput("zero busy in done", {31'b0, busy}, 32'd1);
    tick();
    checkOutput("zero idle", {31'b0, busy}, 32'd0);

    // Fairness: both requesters always valid, grants must alternate starting at 0.
    doReset();
    applyStimulus(2'b11, 4'd3, 4'd4, 4'd5, 4'd6, 1'b1);
    for (int i = 0; i < 8; i++) begin
      waitResult(lat, p, id);
      checkOutput($sformatf("fair id %0d", i), {31'b0, id}, 32'(i % 2));
      checkOutput($sformatf("fair product %0d", i), {24'b0, p}, (i % 2 == 1) ? 32'd30 : 32'd12);
      tick();
    end

    // Randomized traffic with occasional resets; the compare process does the checking.
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        applyStimulus(2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom),
                      4'($urandom), ($urandom_range(0, 3) != 0));
        tick();
      end
    end
    applyStimulus(2'b00, 4'd0, 4'd0, 4'd0, 4'd0, 1'b1);
    repeat (10) tick();
    checkOutput("drain idle", {31'b0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
